// File: rtl/sram_access_seq.sv
// Sequences one asynchronous SRAM cycle (setup, wait states, hold, turnaround) per control-unit strobe.
// Optional SRAM_SEQ_STATS_EN adds Rd_Count/Wr_Count completion counters.
module sram_access_seq #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Ready,
    output logic              Busy,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ
`ifdef SRAM_SEQ_STATS_EN
    ,
    output logic [15:0]       Rd_Count,
    output logic [15:0]       Wr_Count
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        TURN
    } state_t;

    localparam logic [3:0] WS_LD   = 4'(WAIT_STATES);
    localparam logic [3:0] TURN_LD = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              armed;
    logic              accept;
    logic              dq_en;
    logic [DATA_W-1:0] wr_data;

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_en ? wr_data : {DATA_W{1'bz}};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                // Write wins when both strobes are low.
                if (armed && (!Mem_WE || !Mem_OE)) begin
                    accept = 1'b1;
                    if (!Mem_WE) begin
                        state_n = WR_SETUP;
                    end else begin
                        state_n = RD_WAIT;
                        cnt_n   = WS_LD;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) state_n = RD_DONE;
                else             cnt_n   = cnt - 4'd1;
            end
            RD_DONE:  state_n = IDLE;
            WR_SETUP: begin
                state_n = WR_PULSE;
                cnt_n   = WS_LD;
            end
            WR_PULSE: begin
                if (cnt == 4'd0) state_n = WR_HOLD;
                else             cnt_n   = cnt - 4'd1;
            end
            WR_HOLD: begin
                if (TURN_CYCLES == 0) begin
                    state_n = IDLE;
                end else begin
                    state_n = TURN;
                    cnt_n   = TURN_LD;
                end
            end
            TURN: begin
                if (cnt == 4'd0) state_n = IDLE;
                else             cnt_n   = cnt - 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        dq_en     = 1'b0;
        Mem_Ready = 1'b0;
        Busy      = (state != IDLE);
        unique case (state)
            RD_WAIT: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
            end
            RD_DONE: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = 1'b0;
                Mem_Ready = 1'b1;
            end
            WR_SETUP: begin
                SRAM_CE_N = 1'b0;
                dq_en     = 1'b1;
            end
            WR_PULSE: begin
                SRAM_CE_N = 1'b0;
                SRAM_WE_N = 1'b0;
                dq_en     = 1'b1;
            end
            WR_HOLD: begin
                SRAM_CE_N = 1'b0;
                dq_en     = 1'b1;
                Mem_Ready = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            armed       <= 1'b0;
            SRAM_ADDR   <= '0;
            wr_data     <= '0;
            Data_to_CPU <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // A held strobe must be released (both high) before it can start another access.
            if (accept)                armed <= 1'b0;
            else if (Mem_OE && Mem_WE) armed <= 1'b1;
            if (accept) begin
                SRAM_ADDR <= ADDR;
                if (!Mem_WE) wr_data <= Data_from_CPU;
            end
            // Capture on the edge entering RD_DONE so data is valid alongside Mem_Ready.
            if (state == RD_WAIT && state_n == RD_DONE) Data_to_CPU <= SRAM_DQ;
        end
    end

`ifdef SRAM_SEQ_STATS_EN
    logic [15:0] rd_cnt, wr_cnt;
    assign Rd_Count = rd_cnt;
    assign Wr_Count = wr_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_cnt <= 16'd0;
            wr_cnt <= 16'd0;
        end else begin
            if (state == RD_DONE) rd_cnt <= rd_cnt + 16'd1;
            if (state == WR_HOLD) wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with a behavioural async SRAM on SRAM_DQ.
module tb_sram_access_seq;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_OE = 1'b1;
    logic        Mem_WE = 1'b1;
    logic [19:0] ADDR = '0;
    logic [15:0] Data_from_CPU = '0;
    logic [15:0] Data_to_CPU;
    logic        Mem_Ready, Busy;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
`ifdef SRAM_SEQ_STATS_EN
    logic [15:0] Rd_Count, Wr_Count;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mem [0:4095];

    sram_access_seq #(.ADDR_W(20), .DATA_W(16), .WAIT_STATES(1), .TURN_CYCLES(1)) dut (
        .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .ADDR(ADDR),
        .Data_from_CPU(Data_from_CPU), .Data_to_CPU(Data_to_CPU), .Mem_Ready(Mem_Ready),
        .Busy(Busy), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ)
`ifdef SRAM_SEQ_STATS_EN
        , .Rd_Count(Rd_Count), .Wr_Count(Wr_Count)
`endif
    );

    always #5 Clk = ~Clk;

    // Behavioural SRAM: drives on OE read, captures on the rising edge of WE_N.
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[11:0]] : 16'bz;
    always @(posedge SRAM_WE_N) if (SRAM_CE_N === 1'b0) mem[SRAM_ADDR[11:0]] = SRAM_DQ;

    typedef struct {
        logic        oe, we;
        logic [19:0] addr;
        logic [15:0] din;
        logic        ce_n, oe_n, we_n, rdy, busy, dqen;
        logic [15:0] dout;
        logic [19:0] sram_addr;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input bit oe, input bit we, input logic [19:0] a, input logic [15:0] d,
                                input bit ce_n, input bit oe_n, input bit we_n, input bit rdy,
                                input bit busy, input bit dqen, input logic [15:0] dout,
                                input logic [19:0] sa);
        vec_t v;
        v.oe = oe; v.we = we; v.addr = a; v.din = d;
        v.ce_n = ce_n; v.oe_n = oe_n; v.we_n = we_n; v.rdy = rdy; v.busy = busy; v.dqen = dqen;
        v.dout = dout; v.sram_addr = sa;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

`ifdef SRAM_SEQ_STATS_EN
    task automatic do_access(input bit wr, input logic [19:0] a, input logic [15:0] d);
        bit seen;
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        step();
        ADDR = a; Data_from_CPU = d;
        if (wr) Mem_WE = 1'b0; else Mem_OE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (Mem_Ready) seen = 1'b1;
        end
        chk($sformatf("stats_access_done_%0h", a), {31'd0, seen}, 32'd1);
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        for (int i = 0; i < 4; i++) step();
    endtask
`endif

    initial begin
        int rdy_n, oe_lo, we_lo;
        bit seen;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h123] = 16'hBEEF;

        //          oe we addr      din       ce oe we rdy busy dqen dout      sram_addr
        tbl[0]  = mk(H, H, 20'h0,   16'h0,    H, H, H, L, L, L, 16'h0000, 20'h00000);
        tbl[1]  = mk(L, H, 20'h123, 16'h0,    L, L, H, L, H, L, 16'h0000, 20'h00123);
        tbl[2]  = mk(L, H, 20'h123, 16'h0,    L, L, H, L, H, L, 16'h0000, 20'h00123);
        tbl[3]  = mk(L, H, 20'h123, 16'h0,    L, L, H, H, H, L, 16'hBEEF, 20'h00123);
        tbl[4]  = mk(H, H, 20'h0,   16'h0,    H, H, H, L, L, L, 16'hBEEF, 20'h00123);
        tbl[5]  = mk(H, L, 20'h456, 16'h1234, L, H, H, L, H, H, 16'hBEEF, 20'h00456);
        tbl[6]  = mk(H, H, 20'h0,   16'h0,    L, H, L, L, H, H, 16'hBEEF, 20'h00456);
        tbl[7]  = mk(H, H, 20'h0,   16'h0,    L, H, L, L, H, H, 16'hBEEF, 20'h00456);
        tbl[8]  = mk(H, H, 20'h0,   16'h0,    L, H, H, H, H, H, 16'hBEEF, 20'h00456);
        tbl[9]  = mk(H, H, 20'h0,   16'h0,    H, H, H, L, H, L, 16'hBEEF, 20'h00456);
        tbl[10] = mk(H, H, 20'h0,   16'h0,    H, H, H, L, L, L, 16'hBEEF, 20'h00456);
        tbl[11] = mk(L, H, 20'h456, 16'h0,    L, L, H, L, H, L, 16'hBEEF, 20'h00456);
        tbl[12] = mk(L, H, 20'h456, 16'h0,    L, L, H, L, H, L, 16'hBEEF, 20'h00456);
        tbl[13] = mk(L, H, 20'h456, 16'h0,    L, L, H, H, H, L, 16'h1234, 20'h00456);
        tbl[14] = mk(H, H, 20'h0,   16'h0,    H, H, H, L, L, L, 16'h1234, 20'h00456);

        // Reset held three cycles
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        chk("rst_oe_n", {31'd0, SRAM_OE_N}, 32'd1);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_dq_en", {31'd0, dut.dq_en}, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_ready", {31'd0, Mem_Ready}, 32'd0);
        chk("rst_dout", {16'd0, Data_to_CPU}, 32'h0000);
        chk("rst_addr", {12'd0, SRAM_ADDR}, 32'h0);
        chk("ub_lb", {30'd0, SRAM_UB_N, SRAM_LB_N}, 32'd0);
        Reset = 1'b0;

        // Cycle-by-cycle read 0x123, write 0x456, read back 0x456
        for (int i = 0; i < 15; i++) begin
            Mem_OE = tbl[i].oe; Mem_WE = tbl[i].we;
            ADDR = tbl[i].addr; Data_from_CPU = tbl[i].din;
            step();
            chk($sformatf("v%0d_ce_n", i), {31'd0, SRAM_CE_N}, {31'd0, tbl[i].ce_n});
            chk($sformatf("v%0d_oe_n", i), {31'd0, SRAM_OE_N}, {31'd0, tbl[i].oe_n});
            chk($sformatf("v%0d_we_n", i), {31'd0, SRAM_WE_N}, {31'd0, tbl[i].we_n});
            chk($sformatf("v%0d_ready", i), {31'd0, Mem_Ready}, {31'd0, tbl[i].rdy});
            chk($sformatf("v%0d_busy", i), {31'd0, Busy}, {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_dq_en", i), {31'd0, dut.dq_en}, {31'd0, tbl[i].dqen});
            chk($sformatf("v%0d_dout", i), {16'd0, Data_to_CPU}, {16'd0, tbl[i].dout});
            chk($sformatf("v%0d_sram_addr", i), {12'd0, SRAM_ADDR}, {12'd0, tbl[i].sram_addr});
            if (tbl[i].dqen) chk($sformatf("v%0d_dq", i), {16'd0, SRAM_DQ}, 32'h1234);
        end

        // Held read strobe yields one access; release and reassert yields another
        Mem_OE = 1'b0; ADDR = 20'h123;
        rdy_n = 0; oe_lo = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (Mem_Ready) rdy_n++;
            if (!SRAM_OE_N) oe_lo++;
        end
        chk("held_ready_count", rdy_n, 1);
        chk("held_oe_low_cycles", oe_lo, 3);
        chk("held_dout", {16'd0, Data_to_CPU}, 32'hBEEF);
        Mem_OE = 1'b1;
        step();
        mem[12'h123] = 16'hCAFE;
        Mem_OE = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (Mem_Ready) seen = 1'b1;
        end
        chk("rearm_second_read", {31'd0, seen}, 32'd1);
        chk("rearm_dout", {16'd0, Data_to_CPU}, 32'hCAFE);
        Mem_OE = 1'b1;
        step(); step();

        // Both strobes low: write wins, OE_N never asserted
        Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 20'h789; Data_from_CPU = 16'hA5A5;
        rdy_n = 0; oe_lo = 0; we_lo = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (Mem_Ready) rdy_n++;
            if (!SRAM_OE_N) oe_lo++;
            if (!SRAM_WE_N) we_lo++;
        end
        Mem_OE = 1'b1; Mem_WE = 1'b1;
        step(); step();
        chk("both_oe_low_cycles", oe_lo, 0);
        chk("both_we_low_cycles", we_lo, 2);
        chk("both_ready_count", rdy_n, 1);
        chk("both_mem_written", {16'd0, mem[12'h789]}, 32'hA5A5);
        chk("both_dout_kept", {16'd0, Data_to_CPU}, 32'hCAFE);

        // Reset during WR_PULSE abandons the access
        Mem_WE = 1'b0; ADDR = 20'h0AA; Data_from_CPU = 16'h5555;
        step();
        Mem_WE = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step();
            if (!SRAM_WE_N) seen = 1'b1;
        end
        chk("abort_reached_pulse", {31'd0, seen}, 32'd1);
        Reset = 1'b1;
        step();
        chk("abort_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("abort_ce_n", {31'd0, SRAM_CE_N}, 32'd1);
        chk("abort_dq_en", {31'd0, dut.dq_en}, 32'd0);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_ready", {31'd0, Mem_Ready}, 32'd0);
        chk("abort_dout_cleared", {16'd0, Data_to_CPU}, 32'h0000);
        Reset = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (Mem_Ready || Busy) rdy_n++;
        end
        chk("abort_no_late_activity", rdy_n, 0);

`ifdef SRAM_SEQ_STATS_EN
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("stats_reset_rd", {16'd0, Rd_Count}, 32'd0);
        do_access(1'b0, 20'h001, 16'h0);
        do_access(1'b1, 20'h002, 16'h1111);
        do_access(1'b0, 20'h003, 16'h0);
        do_access(1'b1, 20'h004, 16'h2222);
        do_access(1'b0, 20'h005, 16'h0);
        chk("stats_rd_count", {16'd0, Rd_Count}, 32'd3);
        chk("stats_wr_count", {16'd0, Wr_Count}, 32'd2);
        #3 force dut.wr_cnt = 16'hFFFF;
        #1 release dut.wr_cnt;
        do_access(1'b1, 20'h006, 16'h3333);
        chk("stats_wr_wrap", {16'd0, Wr_Count}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
